// File: rtl/fifo_tx_drain_ctrl_if.sv
// FIFO show-ahead read port plus UART TX load/busy handshake,
// bundled between the drain controller and its two neighbours.
interface fifo_tx_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_busy;

  modport master (
    input  rempty,
    input  rdata,
    output rinc,
    output tx_data,
    output tx_valid,
    input  tx_busy
  );

  modport slave (
    output rempty,
    output rdata,
    input  rinc,
    input  tx_data,
    input  tx_valid,
    output tx_busy
  );
endinterface

// File: rtl/fifo_tx_drain_ctrl.sv
// Read-domain sequencer: drains the async FIFO one byte at a time
// into the UART TX, with a busy-rise watchdog and a delivered count.
module fifo_tx_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TMO   = 15,
  parameter int TMO_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  fifo_tx_drain_ctrl_if.master bus,
  input  logic                 err_clr,
  output logic                 err_timeout,
  output logic                 active,
  output logic [CNT_W-1:0]     byte_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(BUSY_TMO);

  state_t                state;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [TMO_W-1:0]      tmo_nxt;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  rinc_q;
  logic                  valid_q;
  logic                  launch_ok;

  assign tmo_nxt   = tmo_cnt + 1'b1;
  assign launch_ok = en && !bus.rempty && !bus.tx_busy;

  assign bus.tx_data  = tx_q;
  assign bus.rinc     = rinc_q;
  assign bus.tx_valid = valid_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      tx_q        <= '0;
      rinc_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_timeout <= 1'b0;
      active      <= 1'b0;
      byte_cnt    <= '0;
    end else begin
      rinc_q  <= 1'b0;
      valid_q <= 1'b0;
      // a timeout in this cycle overrides the clear below
      if (err_clr)
        err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch_ok) begin
            tx_q    <= bus.rdata;
            rinc_q  <= 1'b1;
            valid_q <= 1'b1;
            active  <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= WAIT_DONE;
          end else if (tmo_nxt == TMO_LIM) begin
            tmo_cnt     <= tmo_nxt;
            err_timeout <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Scenario bench for fifo_tx_drain_ctrl: FIFO and TX models,
// launch scoreboard, one task per scenario.
module tb_fifo_tx_drain_ctrl;

  localparam int DW    = 8;
  localparam int CNT_W = 2;

  logic             rclk;
  logic             rrst_n;
  logic             en;
  logic             err_clr;
  logic             err_timeout;
  logic             active;
  logic [CNT_W-1:0] byte_cnt;

  fifo_tx_drain_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_tx_drain_ctrl #(
    .DATA_WIDTH(DW),
    .BUSY_TMO  (15),
    .TMO_W     (4),
    .CNT_W     (CNT_W)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .en         (en),
    .bus        (bus.master),
    .err_clr    (err_clr),
    .err_timeout(err_timeout),
    .active     (active),
    .byte_cnt   (byte_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int unsigned errors;
  int unsigned checks;
  int unsigned launches;
  int unsigned pops;
  logic [DW-1:0]    fifo_q[$];
  logic [DW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  bit               tx_dead;
  int               busy_len;

  task automatic fifo_sync();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_sync();
  endtask

  task automatic fifo_model();
    logic r;
    forever begin
      @(posedge rclk);
      r = bus.rinc;
      #1;
      if (r) begin
        pops++;
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL underflow: rinc=1 got, required 0 (empty)");
        end else begin
          void'(fifo_q.pop_front());
        end
      end
      fifo_sync();
    end
  endtask

  task automatic tx_model();
    forever begin
      @(negedge rclk);
      if (rrst_n && bus.tx_valid && !tx_dead) begin
        @(posedge rclk);
        #1 bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge rclk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  endtask

  task automatic launch_mon();
    logic [DW-1:0] e;
    forever begin
      @(negedge rclk);
      if (rrst_n && bus.tx_valid) begin
        launches++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: tx_data=%h got, none expected",
                   bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            errors++;
            $display("FAIL sb_data: tx_data=%h got, %h required",
                     bus.tx_data, e);
          end
        end
        checks++;
        if (bus.rinc !== 1'b1) begin
          errors++;
          $display("FAIL sb_rinc: rinc=%b got, 1 required", bus.rinc);
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL sb_busy: tx_busy=%b at launch, 0 required",
                   bus.tx_busy);
        end
      end else if (rrst_n && bus.rinc) begin
        checks++;
        errors++;
        $display("FAIL sb_stray_rinc: rinc=1 got without tx_valid");
      end
    end
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge rclk);
      #1 n++;
    end while (n < 200 &&
               (fifo_q.size() != 0 || active || bus.tx_busy));
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_tmo: active=%b got, 0 required",
               tag, active);
    end
  endtask

  task automatic wait_launch(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge rclk);
      #1 n++;
    end while (n < 50 && !bus.tx_valid);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_launch_tmo: tx_valid=0 got, 1 required", tag);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge rclk);
      #1 n++;
    end while (n < 50 && bus.tx_busy !== lvl);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_busy_tmo: tx_busy=%b got, %b required",
               tag, bus.tx_busy, lvl);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge rclk);
    #1;
    checks++;
    if ({bus.rinc, bus.tx_valid, err_timeout, active} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags: %b got, 0000 required",
               {bus.rinc, bus.tx_valid, err_timeout, active});
    end
    checks++;
    if (bus.tx_data !== 8'h00 || byte_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_regs: data=%h cnt=%0d got, 00/0 required",
               bus.tx_data, byte_cnt);
    end
    rrst_n = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    checks++;
    if (active !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: active=%b valid=%b got, 0/0 required",
               active, bus.tx_valid);
    end
  endtask

  task automatic test_single();
    busy_len = 10;
    push_byte(8'hA5);
    en = 1'b1;
    wait_busy(1'b1, "single");
    wait_busy(1'b0, "single");
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL single_active_hi: %b got, 1 required", active);
    end
    @(posedge rclk);
    #1;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL single_active_lo: %b got, 0 required", active);
    end
    exp_cnt++;
    checks++;
    if (byte_cnt !== exp_cnt || launches != 1 || pops != 1) begin
      errors++;
      $display("FAIL single_cnt: cnt=%0d l=%0d p=%0d, %0d/1/1 req",
               byte_cnt, launches, pops, exp_cnt);
    end
  endtask

  task automatic test_burst();
    int l0;
    l0 = launches;
    busy_len = 4;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_drained("burst");
    exp_cnt += 2'd3;
    checks++;
    if (byte_cnt !== exp_cnt || launches - l0 != 3) begin
      errors++;
      $display("FAIL burst_cnt: cnt=%0d l=%0d got, %0d/3 required",
               byte_cnt, launches - l0, exp_cnt);
    end
    checks++;
    if (pops != launches) begin
      errors++;
      $display("FAIL burst_pops: %0d got, %0d required",
               pops, launches);
    end
  endtask

  task automatic test_timeout();
    tx_dead = 1'b1;
    push_byte(8'h5A);
    wait_launch("tmo");
    repeat (15) @(posedge rclk);
    #1;
    checks++;
    if (err_timeout !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: err=%b act=%b got, 0/1 required",
               err_timeout, active);
    end
    @(posedge rclk);
    #1;
    checks++;
    if (err_timeout !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("FAIL tmo_set: err=%b act=%b got, 1/0 required",
               err_timeout, active);
    end
    checks++;
    if (byte_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL tmo_cnt: %0d got, %0d required",
               byte_cnt, exp_cnt);
    end
    tx_dead = 1'b0;
    push_byte(8'h6B);
    wait_drained("tmo_next");
    exp_cnt++;
    checks++;
    if (byte_cnt !== exp_cnt || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_next: cnt=%0d err=%b got, %0d/1 required",
               byte_cnt, err_timeout, exp_cnt);
    end
    err_clr = 1'b1;
    @(posedge rclk);
    #1 err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr: %b got, 0 required", err_timeout);
    end
    tx_dead = 1'b1;
    push_byte(8'h7C);
    wait_launch("tmo2");
    repeat (15) @(posedge rclk);
    #1 err_clr = 1'b1;
    @(posedge rclk);
    #1 err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set_wins: %b got, 1 required", err_timeout);
    end
    tx_dead = 1'b0;
    err_clr = 1'b1;
    @(posedge rclk);
    #1 err_clr = 1'b0;
  endtask

  task automatic test_en_gating();
    int l0;
    l0 = launches;
    busy_len = 6;
    push_byte(8'h77);
    push_byte(8'h88);
    wait_busy(1'b1, "en");
    en = 1'b0;
    wait_busy(1'b0, "en");
    repeat (8) @(posedge rclk);
    #1;
    checks++;
    if (launches - l0 != 1 || bus.rempty !== 1'b0 || active) begin
      errors++;
      $display("FAIL en_hold: l=%0d empty=%b act=%b, 1/0/0 required",
               launches - l0, bus.rempty, active);
    end
    en = 1'b1;
    wait_drained("en");
    exp_cnt += 2'd2;
    checks++;
    if (launches - l0 != 2 || byte_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL en_resume: l=%0d cnt=%0d got, 2/%0d required",
               launches - l0, byte_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    push_byte(8'h3C);
    wait_launch("rstmid");
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rinc, bus.tx_valid, active} !== 3'b0 ||
        byte_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async: ri/va/ac=%b cnt=%0d, 000/0 req",
               {bus.rinc, bus.tx_valid, active}, byte_cnt);
    end
    exp_cnt = '0;
    en = 1'b0;
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    repeat (5) @(posedge rclk);
    #1;
    checks++;
    if (active !== 1'b0 || fifo_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_idle: act=%b fifo=%0d got, 0/1 required",
               active, fifo_q.size());
    end
    en = 1'b1;
    wait_drained("rstmid");
    exp_cnt++;
    checks++;
    if (byte_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL rstmid_cnt: %0d got, %0d required",
               byte_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    en = 1'b0;
    @(posedge rclk);
    #1 rrst_n = 1'b0;
    @(posedge rclk);
    #1 rrst_n = 1'b1;
    en = 1'b1;
    busy_len = 2;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hC0 + 8'(i));
      wait_drained("wrap");
      checks++;
      if (byte_cnt !== CNT_W'(wrap_exp[i])) begin
        errors++;
        $display("FAIL wrap_%0d: %0d got, %0d required",
                 i, byte_cnt, wrap_exp[i]);
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    launches = 0;
    pops     = 0;
    exp_cnt  = '0;
    tx_dead  = 1'b0;
    busy_len = 10;
    rrst_n   = 1'b0;
    en       = 1'b0;
    err_clr  = 1'b0;
    bus.tx_busy = 1'b0;
    fifo_sync();
    fork
      fifo_model();
      tx_model();
      launch_mon();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_en_gating();
    test_reset_mid();
    test_wrap();
    repeat (3) @(posedge rclk);
    #1;
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL sb_left: exp=%0d fifo=%0d got, 0/0 required",
               exp_q.size(), fifo_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
